astar_rd_resp_gen: RTL and testbench
====================================

Name: astar_rd_resp_gen

Overview:
- Responder side of the worker read-request interface (arvalid/araddr/arsize/arlen/resp_task/resp_subtype/resp_mark_last).
- Accepts one burst request with its task context and issues one single-word read per beat to the tile memory port.
- Returns each memory beat as a task-with-data (task, data, word_id, subtype, cq_slot, last) to the worker stage selected by the subtype.
- Sits between the astar worker pipeline and the tile L1/memory read port.

Parameters:
TILE_ID, 0, tile index (debug display only)
LOG_DEPTH, 4, log2 of response buffer depth; also caps outstanding reads

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
arvalid  in  1  burst request valid
arready  out  1  request accepted when arvalid&arready
araddr  in  32  byte address of beat 0
arsize  in  3  log2 bytes per beat; only 2 or 3 legal
arlen  in  8  beats minus one
resp_task  in  $bits(task_t)  task context copied onto every beat
resp_subtype  in  $bits(subtype_t)  destination subtype
resp_mark_last  in  1  flag the final beat as last
in_cq_slot  in  $bits(cq_slice_slot_t)  owning CQ slot
mem_valid  out  1  single-word read request
mem_ready  in  1  memory accepts request
mem_addr  out  32  read address
mem_size  out  3  = latched arsize
mem_rvalid  in  1  in-order read data valid (no backpressure)
mem_rdata  in  64  read data
out_valid  out  1  beat task valid
out_ready  in  1  consumer ready
out_task  out  $bits(task_t)  latched resp_task
out_data  out  $bits(data_t)  beat data
out_word_id  out  $bits(byte_t)  beat index 0..arlen
out_subtype  out  $bits(subtype_t)  latched resp_subtype
out_cq_slot  out  $bits(cq_slice_slot_t)  latched in_cq_slot
out_last  out  1  last beat of a marked burst
stat_beats  out  32  beats delivered (optional feature)
stat_stalls  out  32  cycles out_valid&!out_ready (optional feature)

Behaviour:
- Reset: FSM=IDLE, beat counters=0, outstanding=0, FIFO empty. arready=1, mem_valid=0, out_valid=0, out_last=0, stats=0.
- FSM IDLE: arready=1. On arvalid: latch araddr, arsize, arlen, resp_task, resp_subtype, resp_mark_last, in_cq_slot; issue_cnt=0, done_cnt=0; go to ISSUE.
- FSM ISSUE:
  - mem_valid=1 iff outstanding + fifo_count < 2^LOG_DEPTH.
  - mem_addr = base + (issue_cnt << arsize), 32-bit wrap-around.
  - On mem_valid&mem_ready: issue_cnt++.
  - After the handshake with issue_cnt==arlen, go to DRAIN.
- FSM DRAIN: mem_valid=0. When done_cnt==arlen and that beat handshakes on out, go to IDLE. arready stays 0 in ISSUE and DRAIN; the next request is taken the cycle after returning to IDLE.
- Outstanding counter: +1 on mem handshake, -1 on mem_rvalid, both in the same cycle => unchanged.
- mem_rvalid pushes {data, word_id=resp_cnt, last} into the FIFO. The credit rule guarantees no overflow.
  - arsize==2: data = {32'b0, mem_rdata[31:0]}.
  - arsize==3: data = mem_rdata.
  - mem_rvalid with outstanding==0 is dropped.
- Output: out_valid = !fifo_empty, fields taken from the FIFO head. Pop on out_valid&out_ready. out_valid holds and its fields stay stable until accepted. done_cnt++ on each pop.
- out_last = resp_mark_last & (word_id==arlen). Unmarked bursts never assert it.
- arlen=0 gives a single beat. arlen=255 gives 256 beats; word_id is 8-bit and does not wrap within a burst.
- Illegal arsize (not 2 or 3) is treated as 3.
- Latency: first out_valid one cycle after the first mem_rvalid. Throughput is 1 beat/cycle once streaming.
- Reset mid-burst aborts the burst. Memory is reset by the same rstn, so no stale responses arrive.

Optional Feature:
ASTAR_RESP_STATS_EN:
- Defined: stat_beats increments per out handshake; stat_stalls increments per cycle with out_valid&!out_ready. Both saturate at 2^32-1 and reset to 0.
- Undefined: both ports are tied to 0 and no counter logic is built.

Test Plan:
- Single beat: araddr=0x1000, arsize=3, arlen=0, mark_last=1, mem_rdata=0x0000000500000002 -> one mem read at 0x1000; one out beat with data=0x0000000500000002, word_id=0, out_last=1; arready back to 1 after the pop.
- Burst: araddr=0x2000, arsize=3, arlen=3, mark_last=1 -> reads at 0x2000/08/10/18; beats word_id 0..3 in order; out_last only on word_id 3.
- 32-bit zero-extend: arsize=2, arlen=7, mark_last=0, mem_rdata=0xFFFFFFFF_12345678 -> addresses step by 4; data=0x00000000_12345678; out_last never set.
- Backpressure: LOG_DEPTH=2, arlen=15, out_ready=0 -> exactly 4 reads issued, then mem_valid=0; on releasing out_ready all 16 beats arrive in order with none lost.
- Request blocking and reset: a second arvalid during DRAIN is not accepted (arready=0). rstn low mid-burst -> out_valid=0, arready=1, stats=0 on the next cycle.
- Stats with ASTAR_RESP_STATS_EN: arlen=3 with out_ready low for 5 cycles -> stat_beats=4, stat_stalls=5.

Source files
------------

// File: rtl/astar_rd_resp_gen.sv
// Burst read responder: splits one request into single-word tile memory reads and returns each beat as a task-with-data.
// Optional counters are built only when ASTAR_RESP_STATS_EN is defined.
module astar_rd_resp_gen #(
  parameter int unsigned TILE_ID   = 0,
  parameter int unsigned LOG_DEPTH = 4,
  parameter type task_t          = logic [63:0],
  parameter type subtype_t       = logic [3:0],
  parameter type cq_slice_slot_t = logic [3:0],
  parameter type data_t          = logic [63:0],
  parameter type byte_t          = logic [7:0]
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           arvalid,
  output logic           arready,
  input  logic [31:0]    araddr,
  input  logic [2:0]     arsize,
  input  logic [7:0]     arlen,
  input  task_t          resp_task,
  input  subtype_t       resp_subtype,
  input  logic           resp_mark_last,
  input  cq_slice_slot_t in_cq_slot,
  output logic           mem_valid,
  input  logic           mem_ready,
  output logic [31:0]    mem_addr,
  output logic [2:0]     mem_size,
  input  logic           mem_rvalid,
  input  logic [63:0]    mem_rdata,
  output logic           out_valid,
  input  logic           out_ready,
  output task_t          out_task,
  output data_t          out_data,
  output byte_t          out_word_id,
  output subtype_t       out_subtype,
  output cq_slice_slot_t out_cq_slot,
  output logic           out_last,
  output logic [31:0]    stat_beats,
  output logic [31:0]    stat_stalls
);

  localparam logic [LOG_DEPTH+1:0] DEPTH_W = {2'b01, {LOG_DEPTH{1'b0}}};
  localparam logic [LOG_DEPTH:0]   CNT_ONE = {{LOG_DEPTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  typedef struct packed {
    data_t data;
    byte_t word_id;
    logic  last;
  } beat_t;

  state_t         state_q, state_d;
  logic [31:0]    base_q;
  logic [2:0]     size_q;
  logic [7:0]     len_q;
  task_t          task_q;
  subtype_t       sub_q;
  logic           mark_q;
  cq_slice_slot_t slot_q;

  logic [7:0]           issue_cnt_q, done_cnt_q, resp_cnt_q;
  logic [LOG_DEPTH:0]   outst_q, fifo_cnt_q;
  logic [LOG_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
  beat_t                fifo_mem [0:(1<<LOG_DEPTH)-1];

  logic        accept, mem_hs, rsp_take, pop;
  logic [1:0]  shift;
  logic [63:0] rdata_ext;
  beat_t       push_beat, head;

  // Only arsize==2 narrows the beat; every other encoding behaves as 8-byte beats.
  assign shift     = (size_q == 3'd2) ? 2'd2 : 2'd3;
  assign rdata_ext = (size_q == 3'd2) ? {32'b0, mem_rdata[31:0]} : mem_rdata;

  assign accept   = arvalid & arready;
  assign mem_hs   = mem_valid & mem_ready;
  assign rsp_take = mem_rvalid & (outst_q != '0);
  assign pop      = out_valid & out_ready;

  assign mem_addr = base_q + ({24'b0, issue_cnt_q} << shift);
  assign mem_size = size_q;

  assign push_beat.data    = data_t'(rdata_ext);
  assign push_beat.word_id = byte_t'(resp_cnt_q);
  assign push_beat.last    = mark_q & (resp_cnt_q == len_q);

  assign head        = fifo_mem[rd_ptr_q];
  assign out_valid   = (fifo_cnt_q != '0);
  assign out_data    = head.data;
  assign out_word_id = head.word_id;
  assign out_last    = out_valid & head.last;
  assign out_task    = task_q;
  assign out_subtype = sub_q;
  assign out_cq_slot = slot_q;

  always_comb begin
    state_d   = state_q;
    arready   = 1'b0;
    mem_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        arready = 1'b1;
        if (arvalid) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        // Reads in flight plus buffered beats never exceed the buffer, so pushes cannot overflow.
        mem_valid = (({1'b0, outst_q} + {1'b0, fifo_cnt_q}) < DEPTH_W);
        if (mem_valid && mem_ready && (issue_cnt_q == len_q)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (pop && (done_cnt_q == len_q)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      size_q      <= '0;
      len_q       <= '0;
      task_q      <= '0;
      sub_q       <= '0;
      mark_q      <= 1'b0;
      slot_q      <= '0;
      issue_cnt_q <= '0;
      done_cnt_q  <= '0;
      resp_cnt_q  <= '0;
      outst_q     <= '0;
      fifo_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        base_q      <= araddr;
        size_q      <= arsize;
        len_q       <= arlen;
        task_q      <= resp_task;
        sub_q       <= resp_subtype;
        mark_q      <= resp_mark_last;
        slot_q      <= in_cq_slot;
        issue_cnt_q <= '0;
        done_cnt_q  <= '0;
        resp_cnt_q  <= '0;
      end else begin
        if (mem_hs)   issue_cnt_q <= issue_cnt_q + 8'd1;
        if (pop)      done_cnt_q  <= done_cnt_q + 8'd1;
        if (rsp_take) resp_cnt_q  <= resp_cnt_q + 8'd1;
      end
      case ({mem_hs, rsp_take})
        2'b10:   outst_q <= outst_q + CNT_ONE;
        2'b01:   outst_q <= outst_q - CNT_ONE;
        default: outst_q <= outst_q;
      endcase
      case ({rsp_take, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_ONE;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_ONE;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
      if (rsp_take) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)      rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rsp_take) fifo_mem[wr_ptr_q] <= push_beat;
  end

`ifdef ASTAR_RESP_STATS_EN
  logic [31:0] beats_q, stalls_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      beats_q  <= '0;
      stalls_q <= '0;
    end else begin
      if (pop && (beats_q != '1)) beats_q <= beats_q + 32'd1;
      if (out_valid && !out_ready && (stalls_q != '1)) stalls_q <= stalls_q + 32'd1;
    end
  end

  assign stat_beats  = beats_q;
  assign stat_stalls = stalls_q;
`else
  assign stat_beats  = '0;
  assign stat_stalls = '0;
`endif

endmodule

// File: tb/tb_astar_rd_resp_gen.sv
// Self-checking bench for astar_rd_resp_gen: table of bursts plus hand sequences for blocking, stray data, stats and reset.
module tb_astar_rd_resp_gen;

  localparam int unsigned LOG_DEPTH = 2;
  localparam int unsigned DEPTH     = 1 << LOG_DEPTH;

  typedef logic [63:0] task_t;
  typedef logic [3:0]  subtype_t;
  typedef logic [3:0]  slot_t;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [7:0]  len;
    logic        mark;
    logic        fixed_en;
    logic [63:0] fixed_data;
    int          hold;
    int          ready_pct;
    int          mready_pct;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  word_id;
    logic        last;
    task_t       tsk;
    subtype_t    sub;
    slot_t       slot;
  } exp_beat_t;

  logic        clk, rstn;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic [7:0]  arlen;
  task_t       resp_task;
  subtype_t    resp_subtype;
  logic        resp_mark_last;
  slot_t       in_cq_slot;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr;
  logic [2:0]  mem_size;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        out_valid, out_ready;
  task_t       out_task;
  logic [63:0] out_data;
  logic [7:0]  out_word_id;
  subtype_t    out_subtype;
  slot_t       out_cq_slot;
  logic        out_last;
  logic [31:0] stat_beats, stat_stalls;

  astar_rd_resp_gen #(.TILE_ID(0), .LOG_DEPTH(LOG_DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arsize(arsize), .arlen(arlen),
    .resp_task(resp_task), .resp_subtype(resp_subtype), .resp_mark_last(resp_mark_last),
    .in_cq_slot(in_cq_slot),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_size(mem_size),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_task(out_task), .out_data(out_data),
    .out_word_id(out_word_id), .out_subtype(out_subtype), .out_cq_slot(out_cq_slot),
    .out_last(out_last), .stat_beats(stat_beats), .stat_stalls(stat_stalls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  exp_beat_t   exp_out_q[$];
  logic [31:0] exp_addr_q[$];
  logic [2:0]  exp_size;

  logic        mem_fixed_en = 1'b0;
  logic [63:0] mem_fixed_data = '0;
  int          mready_pct = 100;
  logic        inject_stray = 1'b0;
  logic        rsp_pend = 1'b0;
  logic [63:0] rsp_data = '0;
  int          n_reads = 0;

  logic        prev_stall = 1'b0;
  logic [63:0] prev_data;
  logic [7:0]  prev_wid;
  logic        prev_last;
  int          sb_beats = 0;
  int          sb_stalls = 0;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event occurred, required none", name);
  endtask

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return mem_fixed_en ? mem_fixed_data : {a ^ 32'hC3C3_0000, ~a};
  endfunction

  // Memory: handshakes decided at negedge, data returned one cycle after the accepting edge.
  always @(negedge clk) begin
    if (rstn && mem_valid && mem_ready) begin
      n_reads++;
      if (exp_addr_q.size() == 0) fail("unexpected_mem_read");
      else begin
        check("mem_addr", mem_addr, exp_addr_q.pop_front());
        check("mem_size", mem_size, exp_size);
      end
      rsp_pend = 1'b1;
      rsp_data = mem_word(mem_addr);
    end
  end

  always @(posedge clk) begin
    #1;
    mem_rvalid = (rsp_pend && rstn) || inject_stray;
    mem_rdata  = rsp_pend ? rsp_data : 64'hBAD0_BAD0_BAD0_BAD0;
    rsp_pend   = 1'b0;
    mem_ready  = ($urandom_range(99) < mready_pct);
  end

  // Output scoreboard and hold-stability monitor.
  always @(negedge clk) begin
    if (!rstn) begin
      prev_stall = 1'b0;
      sb_beats   = 0;
      sb_stalls  = 0;
    end else begin
      if (prev_stall) begin
        if (!out_valid) fail("out_valid_dropped_while_stalled");
        else begin
          check("hold_data", out_data, prev_data);
          check("hold_word_id", out_word_id, prev_wid);
          check("hold_last", out_last, prev_last);
        end
      end
      if (!out_valid) check("out_last_idle", out_last, 1'b0);
      if (out_valid && out_ready) begin
        sb_beats++;
        if (exp_out_q.size() == 0) fail("unexpected_out_beat");
        else begin
          exp_beat_t e;
          e = exp_out_q.pop_front();
          check("out_data", out_data, e.data);
          check("out_word_id", out_word_id, e.word_id);
          check("out_last", out_last, e.last);
          check("out_task", out_task, e.tsk);
          check("out_subtype", out_subtype, e.sub);
          check("out_cq_slot", out_cq_slot, e.slot);
        end
      end else if (out_valid) sb_stalls++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_wid   = out_word_id;
      prev_last  = out_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_burst(input logic [31:0] addr, input logic [2:0] size, input logic [7:0] len,
                              input logic mark, input task_t tsk, input subtype_t sub, input slot_t slot);
    int unsigned eff;
    eff = (size == 3'd2) ? 2 : 3;
    exp_size = size;
    for (int unsigned i = 0; i <= len; i++) begin
      logic [31:0] a;
      logic [63:0] d;
      exp_beat_t   e;
      a = addr + (i << eff);
      d = mem_word(a);
      if (eff == 2) d = {32'b0, d[31:0]};
      exp_addr_q.push_back(a);
      e.data = d; e.word_id = i[7:0]; e.last = mark && (i == len);
      e.tsk = tsk; e.sub = sub; e.slot = slot;
      exp_out_q.push_back(e);
    end
  endtask

  task automatic send_req(input logic [31:0] addr, input logic [2:0] size, input logic [7:0] len,
                          input logic mark, input task_t tsk, input subtype_t sub, input slot_t slot);
    bit ok;
    ok = 1'b0;
    tick();
    arvalid = 1'b1; araddr = addr; arsize = size; arlen = len;
    resp_mark_last = mark; resp_task = tsk; resp_subtype = sub; in_cq_slot = slot;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (arready) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) fail("request_accept_timeout");
    tick();
    arvalid = 1'b0;
    araddr = $urandom; arlen = 8'($urandom); resp_task = {$urandom, $urandom};
  endtask

  task automatic wait_done(input int pct, input int budget);
    int cyc;
    cyc = 0;
    forever begin
      tick();
      out_ready = ($urandom_range(99) < pct);
      @(negedge clk);
      if (exp_out_q.size() == 0 && arready) break;
      cyc++;
      if (cyc > budget) begin fail("burst_completion_timeout"); break; end
    end
  endtask

  task automatic check_stats(input string tag);
`ifdef ASTAR_RESP_STATS_EN
    check({tag, "_stat_beats"}, stat_beats, sb_beats);
    check({tag, "_stat_stalls"}, stat_stalls, sb_stalls);
`else
    check({tag, "_stat_beats_tied"}, stat_beats, 0);
    check({tag, "_stat_stalls_tied"}, stat_stalls, 0);
`endif
  endtask

  task automatic run_vec(input vec_t v);
    task_t tsk; subtype_t sub; slot_t slot;
    int unsigned nbeats;
    tsk = {$urandom, $urandom}; sub = 4'($urandom); slot = 4'($urandom);
    nbeats = int'(v.len) + 1;
    mem_fixed_en = v.fixed_en; mem_fixed_data = v.fixed_data;
    mready_pct = v.mready_pct;
    n_reads = 0;
    out_ready = (v.hold > 0) ? 1'b0 : 1'b1;
    expect_burst(v.addr, v.size, v.len, v.mark, tsk, sub, slot);
    send_req(v.addr, v.size, v.len, v.mark, tsk, sub, slot);
    if (v.hold > 0) begin
      repeat (v.hold) tick();
      @(negedge clk);
      check("reads_under_backpressure", n_reads, (nbeats < DEPTH) ? nbeats : DEPTH);
      if (nbeats > DEPTH) check("mem_valid_throttled", mem_valid, 1'b0);
    end
    wait_done(v.ready_pct, 40 * int'(nbeats) + 50);
    check("beats_left_in_scoreboard", exp_out_q.size(), 0);
    check("reads_issued", n_reads, nbeats);
    check("arready_after_burst", arready, 1'b1);
    check_stats("burst");
  endtask

  initial begin
    #1_000_000;
    fail("global_timeout");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "bench stopped by watchdog");
  end

  initial begin
    rstn = 1'b0; arvalid = 1'b0; araddr = '0; arsize = 3'd3; arlen = '0;
    resp_task = '0; resp_subtype = '0; resp_mark_last = 1'b0; in_cq_slot = '0;
    out_ready = 1'b1; mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;

    //            addr          size  len     mark fixed data                   hold rdy mrdy
    vecs[0] = '{32'h0000_1000, 3'd3, 8'd0,   1'b1, 1'b1, 64'h0000_0005_0000_0002, 0,  100, 100};
    vecs[1] = '{32'h0000_2000, 3'd3, 8'd3,   1'b1, 1'b0, 64'h0,                   0,  100, 100};
    vecs[2] = '{32'h0000_3000, 3'd2, 8'd7,   1'b0, 1'b1, 64'hFFFF_FFFF_1234_5678, 0,  100, 100};
    vecs[3] = '{32'h0000_4000, 3'd3, 8'd15,  1'b1, 1'b0, 64'h0,                   20, 100, 100};
    vecs[4] = '{32'h0000_8000, 3'd5, 8'd2,   1'b1, 1'b0, 64'h0,                   0,  60,  70};
    vecs[5] = '{32'hFFFF_FFF0, 3'd3, 8'd3,   1'b1, 1'b0, 64'h0,                   0,  50,  50};
    vecs[6] = '{32'h0001_0000, 3'd2, 8'd255, 1'b1, 1'b0, 64'h0,                   0,  80,  80};
    vecs[7] = '{32'h0002_0004, 3'd2, 8'd0,   1'b0, 1'b0, 64'h0,                   0,  100, 100};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_arready", arready, 1'b1);
    check("reset_mem_valid", mem_valid, 1'b0);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_last", out_last, 1'b0);
    check("reset_stat_beats", stat_beats, 0);
    check("reset_stat_stalls", stat_stalls, 0);
    tick();
    rstn = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Stray read data with nothing outstanding must be discarded.
    @(negedge clk); inject_stray = 1'b1;
    @(negedge clk); inject_stray = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check("stray_rvalid_dropped", out_valid, 1'b0);

    // A second request during DRAIN is held off.
    begin
      task_t t;
      t = {$urandom, $urandom};
      mem_fixed_en = 1'b0; mready_pct = 100; n_reads = 0; out_ready = 1'b0;
      expect_burst(32'h0000_5000, 3'd3, 8'd0, 1'b1, t, 4'h3, 4'h9);
      send_req(32'h0000_5000, 3'd3, 8'd0, 1'b1, t, 4'h3, 4'h9);
      repeat (4) tick();
      arvalid = 1'b1; araddr = 32'h0000_9000; arlen = 8'd5;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        check("arready_in_drain", arready, 1'b0);
        tick();
      end
      arvalid = 1'b0;
      check("drain_reads", n_reads, 1);
      wait_done(100, 100);
      check("drain_beats_left", exp_out_q.size(), 0);
    end

    // Stats: four beats held back for five cycles after the first becomes valid.
    tick(); rstn = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    begin
      task_t t;
      bit seen;
      t = {$urandom, $urandom};
      seen = 1'b0;
      n_reads = 0; out_ready = 1'b0;
      expect_burst(32'h0000_6000, 3'd3, 8'd3, 1'b1, t, 4'h1, 4'h2);
      send_req(32'h0000_6000, 3'd3, 8'd3, 1'b1, t, 4'h1, 4'h2);
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (out_valid) begin seen = 1'b1; break; end
      end
      if (!seen) fail("stats_first_beat_timeout");
      repeat (5) @(posedge clk);
      #1 out_ready = 1'b1;
      wait_done(100, 100);
`ifdef ASTAR_RESP_STATS_EN
      check("stats_beats_4", stat_beats, 4);
      check("stats_stalls_5", stat_stalls, 5);
`else
      check("stats_beats_tied", stat_beats, 0);
      check("stats_stalls_tied", stat_stalls, 0);
`endif
    end

    // Reset in the middle of a backpressured burst.
    begin
      task_t t;
      t = {$urandom, $urandom};
      out_ready = 1'b0;
      expect_burst(32'h0000_7000, 3'd3, 8'd15, 1'b1, t, 4'h5, 4'h6);
      send_req(32'h0000_7000, 3'd3, 8'd15, 1'b1, t, 4'h5, 4'h6);
      repeat (6) tick();
      @(negedge clk);
      check("pre_reset_out_valid", out_valid, 1'b1);
      tick();
      rstn = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("midreset_out_valid", out_valid, 1'b0);
      check("midreset_arready", arready, 1'b1);
      check("midreset_mem_valid", mem_valid, 1'b0);
      check("midreset_stat_beats", stat_beats, 0);
      check("midreset_stat_stalls", stat_stalls, 0);
      exp_out_q.delete();
      exp_addr_q.delete();
      tick();
      rstn = 1'b1;
      run_vec(vecs[1]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
